i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, the 7-bit target address it responds to.
REQ-002 SHALL have parameter FILTER_LEN, default 4, the number of consecutive equal samples required before a synchronized SCL/SDA change is accepted.
REQ-003 SHALL have ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
scl_i  input  1  SCL pad input
scl_o  output  1  SCL drive value, constant 0
scl_t  output  1  SCL tristate, constant 1 (no clock stretching)
sda_i  input  1  SDA pad input
sda_o  output  1  SDA drive value, constant 0
sda_t  output  1  SDA tristate; 0 pulls low, 1 releases
wr_strobe  output  1  one-cycle pulse per register byte written
wr_addr  output  4  register index of the write
wr_data  output  8  byte written
busy  output  1  high from accepted START until STOP
addressed  output  1  high while the current transfer matched DEV_ADDR

Function
REQ-004 SHALL pass scl_i/sda_i through a 2-flop synchronizer and then a FILTER_LEN stable-sample filter; the filtered SCL/SDA change 2+FILTER_LEN cycles after the pad change.
REQ-005 SHALL detect START (incl. repeated) as filtered SDA 1->0 while SCL high, and STOP as SDA 0->1 while SCL high, from any state.
REQ-006 SHALL implement states IDLE, ADDR, ACK_ADDR, RX_BYTE, ACK_RX, TX_BYTE, ACK_TX.
REQ-007 START -> ADDR, bit counter cleared, busy=1; STOP -> IDLE, busy=0, addressed=0, sda_t=1 within one cycle.
REQ-008 ADDR SHALL shift SDA MSB-first on each SCL rising edge; after 8 bits, on match of bits[7:1] with DEV_ADDR go to ACK_ADDR, else IDLE with sda_t=1 until next START.
REQ-009 On mismatch SHALL keep busy=1 until STOP but never drive SDA.
REQ-010 SHALL change sda_t only on the cycle after a filtered SCL falling edge.
REQ-011 ACK phases SHALL drive sda_t=0 from the SCL fall after bit 8 to the SCL fall after the 9th clock.
REQ-012 After ACK_ADDR: R/W=0 -> RX_BYTE; R/W=1 -> TX_BYTE, loading reg[ptr].
REQ-013 First RX byte after a write address SHALL set ptr = byte[3:0] with no wr_strobe; subsequent bytes SHALL write reg[ptr], pulse wr_strobe with wr_addr=ptr, wr_data=byte, then ptr increments.
REQ-014 TX_BYTE SHALL drive SDA MSB-first (sda_t = bit value) and increment ptr after bit 8; ACK_TX releases SDA and samples master ACK on SCL rise.
REQ-015 Master ACK (0) -> TX_BYTE with reg[ptr]; NACK (1) -> IDLE-wait with SDA released until STOP/START.
REQ-016 ptr SHALL be 4 bits and wrap 0xF->0x0; it persists across transfers.
REQ-017 Simultaneous START and wr_strobe-producing edge cannot occur; START detected mid-byte SHALL abort the byte without write.
REQ-018 STOP mid-byte SHALL discard the partial byte; no wr_strobe.

Reset
REQ-019 On rst: state IDLE, sda_t=1, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, addressed=0, ptr=0, all 16 registers 0x00, filters at 1.
REQ-020 Reset mid-transfer SHALL release SDA asynchronously; the next valid transfer requires a fresh START.

Structure
REQ-021 State encoding and register count (16) SHALL live in shared package i2c_pkg.
REQ-022 Synchronizer+filter SHALL be sub-module i2c_line_filter, instanced twice (SCL, SDA).
REQ-023 Register file SHALL be flops inside i2c_target_regs.

Verification
REQ-024 START, 0xA0, 0x03, 0xA5, 0x5A, STOP -> 4 ACKs, wr_strobe (3,A5) then (4,5A), busy low after STOP.
REQ-025 START, 0xA0, 0x03, Sr, 0xA1, read 2 bytes ACK/NACK, STOP -> reads 0xA5, 0x5A; SDA released after NACK.
REQ-026 START, 0xA2 (addr 0x51) -> NACK, sda_t stays 1 through STOP, no strobes.
REQ-027 Write ptr 0x0F then 0x11, 0x22 -> strobes (F,11), (0,22).
REQ-028 Assert rst during TX_BYTE with sda_t=0 -> sda_t=1 same cycle, read of reg 3 after fresh START returns 0x00.
REQ-029 STOP after 4 data bits -> no wr_strobe, state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register target:
// FSM state encoding and register file geometry.
package i2c_pkg;

  localparam int REG_COUNT = 16;
  localparam int REG_AW    = $clog2(REG_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    RX_BYTE,
    ACK_RX,
    TX_BYTE,
    ACK_TX
  } state_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Pad and register-write bundle of the I2C target;
// master side drives the pads, slave side is the target.
interface i2c_target_regs_if
  import i2c_pkg::*;
();

  logic              scl_i;
  logic              scl_o;
  logic              scl_t;
  logic              sda_i;
  logic              sda_o;
  logic              sda_t;
  logic              wr_strobe;
  logic [REG_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              addressed;

  modport master (
    output scl_i, sda_i,
    input  scl_o, scl_t, sda_o, sda_t,
    input  wr_strobe, wr_addr, wr_data,
    input  busy, addressed
  );

  modport slave (
    input  scl_i, sda_i,
    output scl_o, scl_t, sda_o, sda_t,
    output wr_strobe, wr_addr, wr_data,
    output busy, addressed
  );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stable-sample glitch filter;
// output moves 2+FILTER_LEN cycles after the pad changes.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic q
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      q   <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= pad;
      s2 <= s1;
      if (s2 == q) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing 16 byte registers with an auto-incrementing
// pointer; first written byte sets the pointer, later bytes write.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 4
) (
  input logic              clk,
  input logic              rst,
  i2c_target_regs_if.slave bus
);

  state_t            state;
  state_t            state_n;
  logic              scl;
  logic              sda;
  logic              scl_q;
  logic              sda_q;
  logic              scl_rise;
  logic              scl_fall;
  logic              start;
  logic              stop;
  logic              byte_done;
  logic              addr_hit;
  logic              rw;
  logic [7:0]        shift;
  logic [7:0]        tx;
  logic [3:0]        bit_cnt;
  logic [REG_AW-1:0] ptr;
  logic              first;
  logic              mack;
  logic              sda_t;
  logic              wr_strobe;
  logic [REG_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              addressed;
  logic [7:0]        regs [REG_COUNT];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk (clk),
    .rst (rst),
    .pad (bus.scl_i),
    .q   (scl)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk (clk),
    .rst (rst),
    .pad (bus.sda_i),
    .q   (sda)
  );

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start     = scl & scl_q & sda_q & ~sda;
  assign stop      = scl & scl_q & ~sda_q & sda;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign addr_hit  = shift[7:1] == DEV_ADDR;
  assign rw        = shift[0];

  assign bus.scl_o     = 1'b0;
  assign bus.scl_t     = 1'b1;
  assign bus.sda_o     = 1'b0;
  assign bus.sda_t     = sda_t;
  assign bus.wr_strobe = wr_strobe;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.busy      = busy;
  assign bus.addressed = addressed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = ADDR;
    end else if (stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        ADDR:     if (byte_done) state_n = addr_hit ? ACK_ADDR : IDLE;
        ACK_ADDR: if (scl_fall)  state_n = rw ? TX_BYTE : RX_BYTE;
        RX_BYTE:  if (byte_done) state_n = ACK_RX;
        ACK_RX:   if (scl_fall)  state_n = RX_BYTE;
        TX_BYTE:  if (byte_done) state_n = ACK_TX;
        ACK_TX:   if (scl_fall)  state_n = mack ? IDLE : TX_BYTE;
        default:  state_n = state;
      endcase
    end
  end

  // SDA only moves on the cycle after a filtered SCL fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      shift     <= '0;
      tx        <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      first     <= 1'b0;
      mack      <= 1'b1;
      sda_t     <= 1'b1;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      addressed <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      scl_q     <= scl;
      sda_q     <= sda;
      wr_strobe <= 1'b0;
      if (start || stop) begin
        bit_cnt   <= '0;
        busy      <= start;
        addressed <= 1'b0;
        sda_t     <= 1'b1;
      end else begin
        if (scl_rise) begin
          case (state)
            ADDR, RX_BYTE: begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end
            TX_BYTE: bit_cnt <= bit_cnt + 4'd1;
            ACK_TX:  mack    <= sda;
            default: ;
          endcase
        end
        if (scl_fall) begin
          case (state)
            ADDR: begin
              if (byte_done && addr_hit) begin
                addressed <= 1'b1;
                sda_t     <= 1'b0;
              end
            end
            ACK_ADDR: begin
              bit_cnt <= '0;
              first   <= ~rw;
              tx      <= regs[ptr];
              sda_t   <= rw ? regs[ptr][7] : 1'b1;
            end
            RX_BYTE: begin
              if (byte_done) begin
                sda_t <= 1'b0;
                first <= 1'b0;
                if (first) begin
                  ptr <= shift[REG_AW-1:0];
                end else begin
                  regs[ptr] <= shift;
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= shift;
                  ptr       <= ptr + 1'b1;
                end
              end
            end
            ACK_RX: begin
              bit_cnt <= '0;
              sda_t   <= 1'b1;
            end
            TX_BYTE: begin
              if (byte_done) begin
                sda_t <= 1'b1;
                ptr   <= ptr + 1'b1;
              end else begin
                sda_t <= tx[6];
                tx    <= {tx[6:0], 1'b0};
              end
            end
            ACK_TX: begin
              bit_cnt <= '0;
              tx      <= regs[ptr];
              sda_t   <= mack ? 1'b1 : regs[ptr][7];
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master,
// write-strobe scoreboard checked by an independent monitor.
module tb_i2c_target_regs;

  localparam int Q = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;

  always #5 clk = ~clk;

  i2c_target_regs_if bus ();

  assign bus.scl_i = scl_drv;
  assign bus.sda_i = sda_drv & bus.sda_t;

  i2c_target_regs #(
    .DEV_ADDR   (7'h50),
    .FILTER_LEN (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks  = 0;
  int          n_pass    = 0;
  int          n_strobes = 0;
  logic [11:0] exp_wr[$];
  logic [11:0] e;
  logic        watch    = 1'b0;
  logic        seen_low = 1'b0;
  logic [7:0]  rd;
  logic        b;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic hold();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; hold();
    scl_drv = 1'b1; hold();
    sda_drv = 1'b0; hold();
    scl_drv = 1'b0; hold();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; hold();
    scl_drv = 1'b1; hold();
    sda_drv = 1'b1; hold();
  endtask

  task automatic send_bit(input logic v);
    sda_drv = v;    hold();
    scl_drv = 1'b1; hold(); hold();
    scl_drv = 1'b0; hold();
  endtask

  task automatic read_bit(output logic v);
    sda_drv = 1'b1; hold();
    scl_drv = 1'b1; hold();
    v = bus.sda_i;  hold();
    scl_drv = 1'b0; hold();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack,
                            input string name);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(a);
    check(name, a, exp_ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      d[i] = v;
    end
    send_bit(ack);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.wr_strobe) begin
      n_strobes++;
      n_checks++;
      if (exp_wr.size() == 0) begin
        $display("FAIL unexpected_strobe: got %h/%h want none",
                 bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_wr.pop_front();
        if ({bus.wr_addr, bus.wr_data} === e) n_pass++;
        else $display("FAIL wr_strobe: got %h/%h want %h/%h",
                      bus.wr_addr, bus.wr_data, e[11:8], e[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (watch && !bus.sda_t) seen_low = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sda_t", bus.sda_t, 1'b1);
    check("rst_scl_t", bus.scl_t, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_addressed", bus.addressed, 1'b0);
    check("rst_strobe", bus.wr_strobe, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 4'h0);
    check("rst_wr_data", bus.wr_data, 8'h00);

    // write 0xA5, 0x5A at 3, 4
    i2c_start();
    check("busy_after_start", bus.busy, 1'b1);
    write_byte(8'hA0, 1'b0, "ack_addr_w");
    check("addressed_w", bus.addressed, 1'b1);
    write_byte(8'h03, 1'b0, "ack_ptr");
    exp_wr.push_back({4'h3, 8'hA5});
    write_byte(8'hA5, 1'b0, "ack_d0");
    exp_wr.push_back({4'h4, 8'h5A});
    write_byte(8'h5A, 1'b0, "ack_d1");
    i2c_stop();
    check("busy_after_stop", bus.busy, 1'b0);
    check("addressed_after_stop", bus.addressed, 1'b0);

    // read back through repeated start
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr_w2");
    write_byte(8'h03, 1'b0, "ack_ptr2");
    i2c_start();
    write_byte(8'hA1, 1'b0, "ack_addr_r");
    read_byte(rd, 1'b0);
    check("read_reg3", rd, 8'hA5);
    read_byte(rd, 1'b1);
    check("read_reg4", rd, 8'h5A);
    seen_low = 1'b0;
    watch = 1'b1;
    hold(); hold();
    check("release_after_nack", seen_low, 1'b0);
    i2c_stop();
    watch = 1'b0;

    // foreign address
    seen_low = 1'b0;
    watch = 1'b1;
    i2c_start();
    write_byte(8'hA2, 1'b1, "nack_addr51");
    check("addressed_miss", bus.addressed, 1'b0);
    check("busy_miss", bus.busy, 1'b1);
    write_byte(8'h11, 1'b1, "nack_data51");
    i2c_stop();
    watch = 1'b0;
    check("miss_never_drives", seen_low, 1'b0);
    check("busy_miss_stop", bus.busy, 1'b0);

    // pointer wrap
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr_wrap");
    write_byte(8'h0F, 1'b0, "ack_ptr_f");
    exp_wr.push_back({4'hF, 8'h11});
    write_byte(8'h11, 1'b0, "ack_wrap0");
    exp_wr.push_back({4'h0, 8'h22});
    write_byte(8'h22, 1'b0, "ack_wrap1");
    i2c_stop();

    // reset while driving a 0 data bit
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr_w3");
    write_byte(8'h03, 1'b0, "ack_ptr3");
    i2c_start();
    write_byte(8'hA1, 1'b0, "ack_addr_r3");
    read_bit(b);
    check("tx_bit7", b, 1'b1);
    check("tx_drive_low", bus.sda_t, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_release", bus.sda_t, 1'b1);
    check("rst_busy2", bus.busy, 1'b0);
    @(negedge clk);
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold();
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr_w4");
    write_byte(8'h03, 1'b0, "ack_ptr4");
    i2c_start();
    write_byte(8'hA1, 1'b0, "ack_addr_r4");
    read_byte(rd, 1'b1);
    check("read_reg3_cleared", rd, 8'h00);
    i2c_stop();

    // stop after half a data byte
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr_w5");
    write_byte(8'h07, 1'b0, "ack_ptr7");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    i2c_stop();
    check("busy_partial_stop", bus.busy, 1'b0);
    check("addressed_partial_stop", bus.addressed, 1'b0);
    write_byte(8'h99, 1'b1, "idle_ignores_byte");
    i2c_stop();

    hold();
    check("scoreboard_drained", exp_wr.size(), 0);
    check("strobe_count", n_strobes, 4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
